// File: rtl/dmi_pkg.sv
// Shared constants and types for the DMI responder: register addresses,
// DMI op/response encodings, abstract-command error codes and field positions.
package dmi_pkg;

    localparam logic [6:0] ADDR_DATA0      = 7'h04;
    localparam logic [6:0] ADDR_DATA1      = 7'h05;
    localparam logic [6:0] ADDR_DMCONTROL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTATUS   = 7'h11;
    localparam logic [6:0] ADDR_ABSTRACTCS = 7'h16;
    localparam logic [6:0] ADDR_COMMAND    = 7'h17;
    localparam logic [6:0] ADDR_PROGBUF0   = 7'h20;

    localparam int PROGBUF_N = 4;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        RESP_OK     = 2'd0,
        RESP_FAILED = 2'd2
    } dmi_resp_e;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_EXCEPTION  = 3'd3,
        CMDERR_HALTRESUME = 3'd4
    } cmderr_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } dmi_state_e;

    // dmcontrol field positions
    localparam int DMCTL_HALTREQ   = 31;
    localparam int DMCTL_RESUMEREQ = 30;
    localparam int DMCTL_NDMRESET  = 1;
    localparam int DMCTL_DMACTIVE  = 0;

    // abstractcs field positions
    localparam int ACS_PBSIZE_LSB = 24;
    localparam int ACS_BUSY       = 12;
    localparam int ACS_CMDERR_LSB = 8;

endpackage

// File: rtl/dmi_abstract_cmd.sv
// Abstract command tracker: busy flag, sticky cmderr and the command
// handshake toward the hart's debug logic.
module dmi_abstract_cmd
    import dmi_pkg::*;
#(
    parameter int CMD_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             cmd_write,
    input  logic [CMD_W-1:0] cmd_wdata,
    input  logic             data_access,
    input  logic [2:0]       cmderr_w1c,
    input  logic             hart_halted,
    input  logic             cmd_ready,
    input  logic             cmd_done,
    input  logic             cmd_exc,
    output logic             busy,
    output logic [2:0]       cmderr,
    output logic             cmd_valid,
    output logic [CMD_W-1:0] cmd
);

    logic             busy_n;
    logic             cmd_valid_n;
    logic [2:0]       cmderr_n;
    logic [CMD_W-1:0] cmd_n;

    // Next-state: completion first, then new requests, then errors; clear wins
    always_comb begin
        busy_n      = busy;
        cmd_valid_n = cmd_valid;
        cmd_n       = cmd;
        cmderr_n    = cmderr & ~cmderr_w1c;

        if (cmd_valid && cmd_ready)
            cmd_valid_n = 1'b0;

        // done may arrive before the handshake completes; it retires both
        if (busy && cmd_done) begin
            busy_n      = 1'b0;
            cmd_valid_n = 1'b0;
            if (cmd_exc)
                cmderr_n = CMDERR_EXCEPTION;
        end

        if (cmd_write) begin
            if (busy) begin
                if (cmderr == CMDERR_NONE)
                    cmderr_n = CMDERR_BUSY;
            end else if (cmderr != CMDERR_NONE) begin
                cmderr_n = cmderr;
            end else if (!hart_halted) begin
                cmderr_n = CMDERR_HALTRESUME;
            end else begin
                cmd_n       = cmd_wdata;
                cmd_valid_n = 1'b1;
                busy_n      = 1'b1;
            end
        end

        if (data_access && busy && cmderr == CMDERR_NONE)
            cmderr_n = CMDERR_BUSY;

        if (clear) begin
            busy_n      = 1'b0;
            cmd_valid_n = 1'b0;
            cmd_n       = '0;
            cmderr_n    = CMDERR_NONE;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            cmd_valid <= 1'b0;
            cmd       <= '0;
            cmderr    <= CMDERR_NONE;
        end else begin
            busy      <= busy_n;
            cmd_valid <= cmd_valid_n;
            cmd       <= cmd_n;
            cmderr    <= cmderr_n;
        end
    end

endmodule

// File: rtl/dmi_responder.sv
// DMI target with a minimal debug-module register set for one hart.
// Optional program buffer (progbuf0..3 at 0x20-0x23) when DMI_PROGBUF_EN is defined.
module dmi_responder
    import dmi_pkg::*;
#(
    parameter int DATACOUNT = 2,
    parameter int CMD_W     = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             debug_req_valid,
    output logic             debug_req_ready,
    input  logic [6:0]       debug_req_bits_addr,
    input  logic [1:0]       debug_req_bits_op,
    input  logic [31:0]      debug_req_bits_data,
    output logic             debug_resp_valid,
    input  logic             debug_resp_ready,
    output logic [1:0]       debug_resp_bits_resp,
    output logic [31:0]      debug_resp_bits_data,
    output logic             halt_req,
    output logic             resume_req,
    output logic             ndmreset,
    output logic             dmactive,
    input  logic             hart_halted,
    input  logic             hart_running_ack,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [CMD_W-1:0] cmd,
    input  logic             cmd_done,
    input  logic             cmd_exc,
    output logic [31:0]      data0,
    output logic [31:0]      data1,
`ifdef DMI_PROGBUF_EN
    output logic [PROGBUF_N-1:0][31:0] progbuf,
`endif
    input  logic             data_we,
    input  logic             data_sel,
    input  logic [31:0]      data_wdata
);

`ifdef DMI_PROGBUF_EN
    localparam logic [4:0] PROGBUF_SIZE = 5'(PROGBUF_N);
`else
    localparam logic [4:0] PROGBUF_SIZE = 5'd0;
`endif

    dmi_state_e  state_q, state_n;
    dmi_op_e     op;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        accept, is_rd, is_wr, pb_hit, dm_clear;
    logic        wr_dmctl, wr_acs, wr_cmd, wr_data0, wr_data1, wr_pb, data_access;
    logic        haltreq_q, resumeack_q, busy;
    logic [2:0]  cmderr;
    logic [1:0]  resp_n;
    logic [31:0] rdata_n;

    assign op     = dmi_op_e'(debug_req_bits_op);
    assign addr   = debug_req_bits_addr;
    assign wdata  = debug_req_bits_data;
    assign accept = debug_req_valid && debug_req_ready;
    assign is_rd  = accept && (op == OP_READ);
    assign is_wr  = accept && (op == OP_WRITE);
`ifdef DMI_PROGBUF_EN
    assign pb_hit = (addr[6:2] == ADDR_PROGBUF0[6:2]);
`else
    assign pb_hit = 1'b0;
`endif

    // While inactive only dmcontrol writes land; everything else is held cleared
    assign wr_dmctl    = is_wr && addr == ADDR_DMCONTROL;
    assign dm_clear    = !dmactive || (wr_dmctl && !wdata[DMCTL_DMACTIVE]);
    assign wr_acs      = is_wr && dmactive && addr == ADDR_ABSTRACTCS;
    assign wr_cmd      = is_wr && dmactive && addr == ADDR_COMMAND;
    assign wr_data0    = is_wr && dmactive && !busy && addr == ADDR_DATA0;
    assign wr_data1    = is_wr && dmactive && !busy && addr == ADDR_DATA1;
    assign wr_pb       = is_wr && dmactive && !busy && pb_hit;
    assign data_access = (is_rd || is_wr) && dmactive &&
                         (addr == ADDR_DATA0 || addr == ADDR_DATA1 || pb_hit);

    dmi_abstract_cmd #(.CMD_W(CMD_W)) u_abstract_cmd (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (dm_clear),
        .cmd_write   (wr_cmd),
        .cmd_wdata   (CMD_W'(wdata)),
        .data_access (data_access),
        .cmderr_w1c  (wr_acs ? wdata[ACS_CMDERR_LSB +: 3] : 3'b000),
        .hart_halted (hart_halted),
        .cmd_ready   (cmd_ready),
        .cmd_done    (cmd_done),
        .cmd_exc     (cmd_exc),
        .busy        (busy),
        .cmderr      (cmderr),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_n;
    end

    // FSM next state: one response per accepted request
    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: if (debug_req_valid)  state_n = ST_RESP;
            ST_RESP: if (debug_resp_ready) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        debug_req_ready  = (state_q == ST_IDLE);
        debug_resp_valid = (state_q == ST_RESP);
    end

    // Read mux and response code for the request being accepted
    always_comb begin
        resp_n  = RESP_OK;
        rdata_n = '0;
        case (op)
            OP_READ: begin
                case (addr)
                    ADDR_DATA0:      rdata_n = data0;
                    ADDR_DATA1:      rdata_n = data1;
                    ADDR_DMCONTROL:  rdata_n = {haltreq_q, 29'd0, ndmreset, dmactive};
                    ADDR_DMSTATUS:   rdata_n = {14'd0, {2{resumeack_q}}, 4'd0,
                                                {2{!hart_halted}}, {2{hart_halted}},
                                                1'b1, 3'd0, 4'd2};
                    ADDR_ABSTRACTCS: rdata_n = {3'd0, PROGBUF_SIZE, 11'd0, busy, 1'b0,
                                                cmderr, 4'd0, 4'(DATACOUNT)};
                    default: begin
`ifdef DMI_PROGBUF_EN
                        if (pb_hit) rdata_n = progbuf[addr[1:0]];
`endif
                    end
                endcase
            end
            OP_RSVD: resp_n = RESP_FAILED;
            default: ;
        endcase
    end

    // Latch the response at acceptance; held until the DTM takes it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            debug_resp_bits_resp <= '0;
            debug_resp_bits_data <= '0;
        end else if (accept) begin
            debug_resp_bits_resp <= resp_n;
            debug_resp_bits_data <= rdata_n;
        end
    end

    // dmcontrol fields and resume request / sticky acknowledge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dmactive    <= 1'b0;
            haltreq_q   <= 1'b0;
            ndmreset    <= 1'b0;
            resume_req  <= 1'b0;
            resumeack_q <= 1'b0;
        end else begin
            if (resume_req && hart_running_ack) begin
                resume_req  <= 1'b0;
                resumeack_q <= 1'b1;
            end
            if (dm_clear) begin
                haltreq_q   <= 1'b0;
                ndmreset    <= 1'b0;
                resume_req  <= 1'b0;
                resumeack_q <= 1'b0;
            end
            if (wr_dmctl) begin
                dmactive  <= wdata[DMCTL_DMACTIVE];
                haltreq_q <= wdata[DMCTL_DMACTIVE] & wdata[DMCTL_HALTREQ];
                ndmreset  <= wdata[DMCTL_DMACTIVE] & wdata[DMCTL_NDMRESET];
                // resume is meaningless while also asking for halt
                if (wdata[DMCTL_DMACTIVE] && wdata[DMCTL_RESUMEREQ] && !wdata[DMCTL_HALTREQ]) begin
                    resume_req  <= 1'b1;
                    resumeack_q <= 1'b0;
                end
            end
        end
    end

    assign halt_req = haltreq_q;

    // Data registers: hart writeback beats a DMI write to the same register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data0 <= '0;
            data1 <= '0;
        end else if (dm_clear) begin
            data0 <= '0;
            data1 <= '0;
        end else begin
            if (data_we && !data_sel) data0 <= data_wdata;
            else if (wr_data0)        data0 <= wdata;
            if (data_we && data_sel)  data1 <= data_wdata;
            else if (wr_data1)        data1 <= wdata;
        end
    end

`ifdef DMI_PROGBUF_EN
    // Program buffer words, writable only while no command is running
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          progbuf <= '0;
        else if (dm_clear)     progbuf <= '0;
        else if (wr_pb)        progbuf[addr[1:0]] <= wdata;
    end
`else
    logic unused_pb;
    assign unused_pb = wr_pb;
`endif

endmodule
